// File: rtl/prf_pkg.sv
// Shared defaults and the write-port bundle type for the physical register file writeback path.
package prf_pkg;

  localparam int unsigned PRF_NUM_REQ = 7;
  localparam int unsigned PRF_ADDR_W  = 6;
  localparam int unsigned PRF_DATA_W  = 64;

  typedef struct packed {
    logic                  valid;
    logic [PRF_ADDR_W-1:0] address;
    logic [PRF_DATA_W-1:0] data;
  } wb_port_t;

endpackage

// File: rtl/prf_wb_rr_pick.sv
// Finds the first set bit of req_vec scanning upward from start with wrap-around.
module prf_wb_rr_pick
  import prf_pkg::*;
#(
  parameter int unsigned NUM_REQ = PRF_NUM_REQ,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_vec,
  input  logic [PTR_W-1:0]   start,
  output logic [PTR_W-1:0]   idx,
  output logic               found
);

  logic [2*NUM_REQ-1:0] rot;

  // Doubling the vector turns the wrap-around scan into a plain LSB-first search.
  assign rot = {req_vec, req_vec} >> start;

  always_comb begin
    int unsigned pos;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = 32'(start) + i;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        idx   = PTR_W'(pos);
      end
    end
  end

endmodule

// File: rtl/prf_wb_arbiter.sv
// Dual-port writeback arbiter for the physical register file.
// Round-robin fairness when PRF_WB_RR_EN is defined, fixed priority (index 0 first) otherwise.
module prf_wb_arbiter
  import prf_pkg::*;
#(
  parameter int unsigned NUM_REQ        = PRF_NUM_REQ,
  parameter int unsigned REG_ADDR_WIDTH = PRF_ADDR_W,
  parameter int unsigned REG_DATA_WIDTH = PRF_DATA_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*REG_DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               wr0_valid,
  output logic [REG_ADDR_WIDTH-1:0]          wr0_address,
  output logic [REG_DATA_WIDTH-1:0]          wr0_data,
  output logic                               wr1_valid,
  output logic [REG_ADDR_WIDTH-1:0]          wr1_address,
  output logic [REG_DATA_WIDTH-1:0]          wr1_data
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [REG_ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [REG_DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]        zero_drop;
  logic [NUM_REQ-1:0]        live;
  logic [NUM_REQ-1:0]        cand1;
  logic [PTR_W-1:0]          start;
  logic [PTR_W-1:0]          idx0;
  logic [PTR_W-1:0]          idx1;
  logic                      found0;
  logic                      found1;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      data_arr[i]  = req_data[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
      zero_drop[i] = req_valid[i] && (addr_arr[i] == '0);
      live[i]      = req_valid[i] && (addr_arr[i] != '0);
    end
  end

`ifdef PRF_WB_RR_EN
  logic [PTR_W-1:0] rr_ptr;

  // Address-0 drops are consumed but never move the pointer; it follows the port grants only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (found1) begin
      rr_ptr <= (idx1 == PTR_W'(NUM_REQ-1)) ? '0 : idx1 + 1'b1;
    end else if (found0) begin
      rr_ptr <= (idx0 == PTR_W'(NUM_REQ-1)) ? '0 : idx0 + 1'b1;
    end
  end

  assign start = rr_ptr;
`else
  assign start = '0;
`endif

  prf_wb_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick0 (
    .req_vec (live),
    .start   (start),
    .idx     (idx0),
    .found   (found0)
  );

  // Second scan excludes the first winner and anything targeting the same register.
  always_comb begin
    cand1 = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand1[i] = live[i] &&
                 !(found0 && ((idx0 == PTR_W'(i)) || (addr_arr[i] == addr_arr[idx0])));
    end
  end

  prf_wb_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick1 (
    .req_vec (cand1),
    .start   (start),
    .idx     (idx1),
    .found   (found1)
  );

  always_comb begin
    req_ready = '0;
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = zero_drop[i] ||
                       (found0 && (idx0 == PTR_W'(i))) ||
                       (found1 && (idx1 == PTR_W'(i)));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr0_valid   <= 1'b0;
      wr0_address <= '0;
      wr0_data    <= '0;
      wr1_valid   <= 1'b0;
      wr1_address <= '0;
      wr1_data    <= '0;
    end else begin
      wr0_valid   <= found0;
      wr0_address <= found0 ? addr_arr[idx0] : '0;
      wr0_data    <= found0 ? data_arr[idx0] : '0;
      wr1_valid   <= found1;
      wr1_address <= found1 ? addr_arr[idx1] : '0;
      wr1_data    <= found1 ? data_arr[idx1] : '0;
    end
  end

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Bench for prf_wb_arbiter: per-cycle reference model plus directed scenarios with literal expectations.
module tb_prf_wb_arbiter;
  import prf_pkg::*;

  localparam int NR = PRF_NUM_REQ;
  localparam int AW = PRF_ADDR_W;
  localparam int DW = PRF_DATA_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NR-1:0]        vld;
  logic [AW-1:0]        ad [NR];
  logic [DW-1:0]        dt [NR];
  logic [NR*AW-1:0]     req_addr;
  logic [NR*DW-1:0]     req_data;
  logic [NR-1:0]        req_ready;
  logic                 wr0_valid, wr1_valid;
  logic [AW-1:0]        wr0_address, wr1_address;
  logic [DW-1:0]        wr0_data, wr1_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = ad[i];
      req_data[i*DW +: DW] = dt[i];
    end
  end

  prf_wb_arbiter #(
    .NUM_REQ        (NR),
    .REG_ADDR_WIDTH (AW),
    .REG_DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (vld),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .wr0_valid   (wr0_valid),
    .wr0_address (wr0_address),
    .wr0_data    (wr0_data),
    .wr1_valid   (wr1_valid),
    .wr1_address (wr1_address),
    .wr1_data    (wr1_data)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: list requesters in scan order, drop address-0 ones, take the first
  // remaining, then the first remaining whose address differs from it.
  function automatic void model(input logic [NR-1:0] v, input int ptr,
                                output logic [NR-1:0] rdy, output int g0, output int g1);
    int order[$];
    int elig[$];
    rdy = '0;
    g0  = -1;
    g1  = -1;
    for (int k = 0; k < NR; k++) order.push_back((ptr + k) % NR);
    foreach (order[n]) begin
      if (v[order[n]]) begin
        if (ad[order[n]] == '0) rdy |= NR'(1) << order[n];
        else elig.push_back(order[n]);
      end
    end
    if (elig.size() > 0) begin
      g0 = elig[0];
      rdy |= NR'(1) << g0;
      foreach (elig[n]) if (g1 < 0 && ad[elig[n]] != ad[g0]) g1 = elig[n];
      if (g1 >= 0) rdy |= NR'(1) << g1;
    end
  endfunction

  int       m_ptr = 0;
  wb_port_t exp0  = '0;
  wb_port_t exp1  = '0;

  always @(negedge clk) begin
    logic [NR-1:0] rdy;
    int g0, g1;
    if (rst) begin
      check("rst_ready", 64'(req_ready), 64'(0));
      check("rst_wr0_valid", 64'(wr0_valid), 64'(0));
      check("rst_wr1_valid", 64'(wr1_valid), 64'(0));
      m_ptr = 0;
      exp0  = '0;
      exp1  = '0;
    end else begin
      check("m_wr0_valid", 64'(wr0_valid), 64'(exp0.valid));
      check("m_wr0_addr", 64'(wr0_address), 64'(exp0.address));
      check("m_wr0_data", wr0_data, exp0.data);
      check("m_wr1_valid", 64'(wr1_valid), 64'(exp1.valid));
      check("m_wr1_addr", 64'(wr1_address), 64'(exp1.address));
      check("m_wr1_data", wr1_data, exp1.data);
      model(vld, m_ptr, rdy, g0, g1);
      check("m_ready", 64'(req_ready), 64'(rdy));
      exp0 = (g0 >= 0) ? '{valid: 1'b1, address: ad[g0], data: dt[g0]} : '0;
      exp1 = (g1 >= 0) ? '{valid: 1'b1, address: ad[g1], data: dt[g1]} : '0;
`ifdef PRF_WB_RR_EN
      if (g1 >= 0) m_ptr = (g1 + 1) % NR;
      else if (g0 >= 0) m_ptr = (g0 + 1) % NR;
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    vld = '0;
    for (int i = 0; i < NR; i++) begin
      ad[i] = '0;
      dt[i] = '0;
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a);
    vld[i] = 1'b1;
    ad[i]  = a;
    dt[i]  = 64'hDA7A_0000_0000_0000 | 64'(i);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [NR-1:0] e_rdy4 [4];
  int            e_a0_4 [4];
  int            e_a1_4 [4];
  logic [NR-1:0] e_rdy3 [3];
  int            e_a0_3 [3];
  int            e_a1_3 [3];

  initial begin
`ifdef PRF_WB_RR_EN
    e_rdy4 = '{7'h03, 7'h0C, 7'h30, 7'h41};
    e_a0_4 = '{1, 3, 5, 7};
    e_a1_4 = '{2, 4, 6, 1};
    e_rdy3 = '{7'h06, 7'h22, 7'h24};
    e_a0_3 = '{10, 12, 11};
    e_a1_3 = '{11, 10, 12};
`else
    e_rdy4 = '{7'h03, 7'h03, 7'h03, 7'h03};
    e_a0_4 = '{1, 1, 1, 1};
    e_a1_4 = '{2, 2, 2, 2};
    e_rdy3 = '{7'h06, 7'h06, 7'h06};
    e_a0_3 = '{10, 10, 10};
    e_a1_3 = '{11, 11, 11};
`endif
    clear_reqs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_wr0_valid", 64'(wr0_valid), 64'(0));
    check("reset_wr1_addr", 64'(wr1_address), 64'(0));

    // basic grant
    set_req(0, 6'd9);
    set_req(2, 6'd5);
    #1 check("basic_ready", 64'(req_ready), 64'(7'b0000101));
    step();
    clear_reqs();
    check("basic_wr0_valid", 64'(wr0_valid), 64'(1));
    check("basic_wr0_addr", 64'(wr0_address), 64'(9));
    check("basic_wr0_data", wr0_data, 64'hDA7A_0000_0000_0000);
    check("basic_wr1_valid", 64'(wr1_valid), 64'(1));
    check("basic_wr1_addr", 64'(wr1_address), 64'(5));
    check("basic_wr1_data", wr1_data, 64'hDA7A_0000_0000_0002);

    // idle
    #1 check("idle_ready", 64'(req_ready), 64'(0));
    step();
    check("idle_wr0_valid", 64'(wr0_valid), 64'(0));
    check("idle_wr1_valid", 64'(wr1_valid), 64'(0));

    // all requesters valid, held
    reset_pulse();
    for (int i = 0; i < NR; i++) set_req(i, AW'(i + 1));
    for (int c = 0; c < 4; c++) begin
      #1 check("all_ready", 64'(req_ready), 64'(e_rdy4[c]));
      step();
      check("all_wr0_addr", 64'(wr0_address), 64'(e_a0_4[c]));
      check("all_wr1_addr", 64'(wr1_address), 64'(e_a1_4[c]));
    end
    clear_reqs();

    // address conflict
    reset_pulse();
    set_req(0, 6'd12);
    set_req(1, 6'd12);
    set_req(3, 6'd7);
    #1 check("conf_ready1", 64'(req_ready), 64'(7'b0001001));
    step();
    vld[0] = 1'b0;
    vld[3] = 1'b0;
    check("conf_wr0_addr", 64'(wr0_address), 64'(12));
    check("conf_wr0_data", wr0_data, 64'hDA7A_0000_0000_0000);
    check("conf_wr1_addr", 64'(wr1_address), 64'(7));
    check("conf_wr1_data", wr1_data, 64'hDA7A_0000_0000_0003);
    #1 check("conf_ready2", 64'(req_ready), 64'(7'b0000010));
    step();
    clear_reqs();
    check("conf2_wr0_data", wr0_data, 64'hDA7A_0000_0000_0001);
    check("conf2_wr1_valid", 64'(wr1_valid), 64'(0));

    // address-0 drop
    set_req(1, 6'd0);
    set_req(4, 6'd3);
    #1 check("zero_ready", 64'(req_ready), 64'(7'b0010010));
    step();
    clear_reqs();
    check("zero_wr0_addr", 64'(wr0_address), 64'(3));
    check("zero_wr0_data", wr0_data, 64'hDA7A_0000_0000_0004);
    check("zero_wr1_valid", 64'(wr1_valid), 64'(0));
    check("zero_wr1_addr", 64'(wr1_address), 64'(0));

    // mid-operation asynchronous reset
    set_req(2, 6'd20);
    step();
    clear_reqs();
    check("mid_pre_wr0_valid", 64'(wr0_valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_wr0_valid", 64'(wr0_valid), 64'(0));
    check("mid_wr0_addr", 64'(wr0_address), 64'(0));
    check("mid_wr0_data", wr0_data, 64'(0));
    check("mid_ready", 64'(req_ready), 64'(0));
    step();
    rst = 1'b0;
    set_req(6, 6'd33);
    #1 check("mid_post_ready", 64'(req_ready), 64'(7'b1000000));
    step();
    clear_reqs();
    check("mid_post_wr0_addr", 64'(wr0_address), 64'(33));
    check("mid_post_wr0_data", wr0_data, 64'hDA7A_0000_0000_0006);
    check("mid_post_wr1_valid", 64'(wr1_valid), 64'(0));

    // priority policy with requesters held
    reset_pulse();
    set_req(1, 6'd10);
    set_req(2, 6'd11);
    set_req(5, 6'd12);
    for (int c = 0; c < 3; c++) begin
      #1 check("prio_ready", 64'(req_ready), 64'(e_rdy3[c]));
      step();
      check("prio_wr0_addr", 64'(wr0_address), 64'(e_a0_3[c]));
      check("prio_wr1_addr", 64'(wr1_address), 64'(e_a1_3[c]));
    end
    clear_reqs();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prf_wb_arbiter.md
PRF_WB_ARBITER -- requirements
Module: prf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 7, meaning the number of writeback requesters.
REQ-002 The block SHALL have parameter REG_ADDR_WIDTH, default 6, meaning the physical register address width.
REQ-003 The block SHALL have parameter REG_DATA_WIDTH, default 64, meaning the register data width.
REQ-004 The block SHALL have these ports:
- clk  in  1  single clock; the block has one clock and reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*REG_ADDR_WIDTH  flattened addresses; requester i occupies slice i.
- req_data  in  NUM_REQ*REG_DATA_WIDTH  flattened data; requester i occupies slice i.
- req_ready  out  NUM_REQ  grant; the request is consumed on valid&ready.
- wr0_valid / wr0_address / wr0_data  out  1 / REG_ADDR_WIDTH / REG_DATA_WIDTH  regfile write port 0, registered.
- wr1_valid / wr1_address / wr1_data  out  1 / REG_ADDR_WIDTH / REG_DATA_WIDTH  regfile write port 1, registered.

Function
REQ-005 Each cycle the block SHALL grant at most 2 requesters: the first and second valid requesters found scanning upward from priority pointer rr_ptr with wrap-around.
REQ-006 req_ready SHALL be combinational from req_valid and rr_ptr.
- Requesters hold valid, address and data stable until ready.
- req_valid SHALL NOT depend on req_ready.
REQ-007 The first grant SHALL be registered onto port 0 and the second onto port 1 at the next rising edge; latency is exactly 1 cycle.
REQ-008 An unused port SHALL register valid=0 with address and data equal to 0.
REQ-009 If the second candidate's address equals the first's, the second SHALL NOT be granted; the next valid requester with a different address in scan order SHALL be taken instead, or none.
REQ-010 A request to address 0 SHALL be granted and consumed but SHALL NOT drive any write port, and SHALL NOT occupy a port slot.
REQ-011 After any cycle with at least one grant, rr_ptr SHALL become (index of last granted requester + 1) mod NUM_REQ; with no grant it SHALL hold.
REQ-012 With no valid requests, both ports SHALL be invalid next cycle and all req_ready SHALL be 0.
REQ-013 The block SHALL never assert more than 2 req_ready bits, excluding address-0 drops, in any cycle.

Reset
REQ-014 While rst=1, all req_ready SHALL be 0.
REQ-015 rst SHALL asynchronously clear wr0_*/wr1_* to 0 and rr_ptr to 0, including mid-operation; in-flight registered writes are discarded.
REQ-016 On the first edge after rst deasserts, normal arbitration SHALL resume with rr_ptr=0.

Configuration
REQ-017 Macro PRF_WB_RR_EN SHALL control the fairness policy.
- Defined: scanning starts at rr_ptr per REQ-005/REQ-011.
- Undefined: rr_ptr is removed and scanning always starts at index 0 (fixed priority, lowest index wins); all other requirements are unchanged.

Structure
REQ-018 The following SHALL reside in the shared package prf_pkg:
- default widths;
- the NUM_REQ default;
- a typedef for a write-port bundle {valid, address, data}.
REQ-019 The block SHALL contain one sub-module, prf_wb_rr_pick, which takes a request vector and start pointer and returns the first-found index with a found flag.
- It SHALL be instantiated twice; the second instance masks the first pick and address-conflicting requesters.

Verification
REQ-020 Scenario, basic grant: req_valid=7'b0000101 with addr2=5 and addr0=9, rr_ptr=0.
- req_ready=7'b0000101 in the same cycle.
- Next cycle: wr0=(1,9,data0) and wr1=(1,5,data2).
- rr_ptr=3.
REQ-021 Scenario, all requesters valid: all 7 valid with distinct nonzero addresses held 4 cycles.
- Grants: {0,1}, {2,3}, {4,5}, then {6,0} (wrap).
REQ-022 Scenario, address conflict: req0 and req1 both addr 12, req3 addr 7.
- Grants: req0 and req3; req1 waits.
- req1 is granted the next cycle.
REQ-023 Scenario, address-0 drop: req1 addr 0, req4 addr 3.
- Both ready.
- Next cycle: wr0=(1,3,data4) and wr1 invalid.
REQ-024 Scenario, mid-operation reset: rst pulsed asynchronously between edges while wr0_valid=1.
- Outputs go to 0 immediately.
- After release, rr_ptr=0 and req6 alone is granted.
REQ-025 Scenario, fixed priority: with PRF_WB_RR_EN undefined and req1, req2 and req5 held valid.
- Grants {1,2} every cycle; req5 is never granted while req1 and req2 stay valid.
